block_stack_judge: RTL and testbench

//  Consumer end of the block-shifter path: takes the moving block position and the raw

---
 rtl/block_stack_judge.sv | 148 ++++++++++++++
 tb/tb_block_stack_judge.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/block_stack_judge.sv
// Stop-button debouncer and stacking judge: latches the moving block on an accepted
// press, keeps the surviving overlap, counts levels and flags win/lose. Option: SPEEDUP_EN.
module block_stack_judge #(
    parameter int WIDTH      = 8,
    parameter int LEVELS     = 8,
    parameter int DEB_TICKS  = 20,
    parameter int BASE_DIV   = 200,
    parameter int SPEED_STEP = 20,
    parameter int MIN_DIV    = 40
) (
    input  logic             clk,
    input  logic             rstBtn,
    input  logic             sampleTick,
    input  logic             stopBtn,
    input  logic [WIDTH-1:0] blockLoc,
    output logic [WIDTH-1:0] lockLoc,
    output logic [3:0]       level,
    output logic [7:0]       speedDiv,
    output logic             stopPulse,
    output logic             gameWin,
    output logic             gameOver
);
    localparam int CW = $clog2(DEB_TICKS + 1);

    typedef enum logic [1:0] {PLAY, CHECK, WIN, OVER} state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_sync;
    logic             w_btnS;
    logic [CW-1:0]    r_cnt;
    logic             r_armed;
    logic             r_pulse;
    logic [WIDTH-1:0] r_cap, w_cap_nxt;
    logic [WIDTH-1:0] r_lock, w_lock_nxt;
    logic [3:0]       r_level, w_level_nxt;
    logic [7:0]       r_speed, w_speed_nxt;
    logic             r_win, w_win_nxt;
    logic             r_over, w_over_nxt;
    logic [WIDTH-1:0] w_ov;
    logic [3:0]       w_lvl_inc;
    logic [7:0]       w_speed_dec;

    assign w_btnS = r_sync[1];

    // The pulse fires on the sample that brings the count to DEB_TICKS; a single low
    // sample clears the count and re-arms.
    always_ff @(posedge clk) begin
        if (rstBtn) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_armed <= 1'b1;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], stopBtn};
            r_pulse <= 1'b0;
            if (sampleTick) begin
                if (w_btnS) begin
                    if (r_cnt != CW'(DEB_TICKS))
                        r_cnt <= r_cnt + 1'b1;
                    if (r_armed && r_cnt == CW'(DEB_TICKS - 1)) begin
                        r_pulse <= 1'b1;
                        r_armed <= 1'b0;
                    end
                end else begin
                    r_cnt   <= '0;
                    r_armed <= 1'b1;
                end
            end
        end
    end

    assign w_ov      = r_cap & r_lock;
    assign w_lvl_inc = r_level + 4'd1;

`ifdef SPEEDUP_EN
    // Compare in int before subtracting so the 8-bit value can never wrap.
    assign w_speed_dec = (int'(r_speed) >= MIN_DIV + SPEED_STEP) ?
                         r_speed - 8'(SPEED_STEP) : 8'(MIN_DIV);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^(SPEED_STEP ^ MIN_DIV);
    assign w_speed_dec  = r_speed;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cap_nxt   = r_cap;
        w_lock_nxt  = r_lock;
        w_level_nxt = r_level;
        w_speed_nxt = r_speed;
        w_win_nxt   = r_win;
        w_over_nxt  = r_over;
        case (r_state)
            PLAY: begin
                if (r_pulse) begin
                    w_cap_nxt   = blockLoc;
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (w_ov == '0) begin
                    w_over_nxt  = 1'b1;
                    w_state_nxt = OVER;
                end else begin
                    w_lock_nxt  = w_ov;
                    w_level_nxt = w_lvl_inc;
                    w_speed_nxt = w_speed_dec;
                    if (w_lvl_inc == 4'(LEVELS)) begin
                        w_win_nxt   = 1'b1;
                        w_state_nxt = WIN;
                    end else begin
                        w_state_nxt = PLAY;
                    end
                end
            end
            WIN:     w_state_nxt = WIN;
            OVER:    w_state_nxt = OVER;
            default: w_state_nxt = PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstBtn) begin
            r_state <= PLAY;
            r_cap   <= '0;
            r_lock  <= '1;
            r_level <= '0;
            r_speed <= 8'(BASE_DIV);
            r_win   <= 1'b0;
            r_over  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cap   <= w_cap_nxt;
            r_lock  <= w_lock_nxt;
            r_level <= w_level_nxt;
            r_speed <= w_speed_nxt;
            r_win   <= w_win_nxt;
            r_over  <= w_over_nxt;
        end
    end

    assign lockLoc   = r_lock;
    assign level     = r_level;
    assign speedDiv  = r_speed;
    assign stopPulse = r_pulse;
    assign gameWin   = r_win;
    assign gameOver  = r_over;
endmodule

// File: tb/tb_block_stack_judge.sv
// Randomized scoreboard bench for block_stack_judge: a game-level model predicts the
// state after every accepted press; a monitor checks it when stopPulse appears.
module tb_block_stack_judge;
    logic       clk = 1'b0;
    logic       rstBtn = 1'b1;
    logic       sampleTick = 1'b0;
    logic       stopBtn = 1'b0;
    logic [7:0] blockLoc = 8'h00;
    logic [7:0] lockLoc;
    logic [3:0] level;
    logic [7:0] speedDiv;
    logic       stopPulse, gameWin, gameOver;

    block_stack_judge dut (
        .clk(clk), .rstBtn(rstBtn), .sampleTick(sampleTick), .stopBtn(stopBtn),
        .blockLoc(blockLoc), .lockLoc(lockLoc), .level(level), .speedDiv(speedDiv),
        .stopPulse(stopPulse), .gameWin(gameWin), .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         skip;
        logic [7:0] prev_lock;
        int         prev_level;
        logic [7:0] lock;
        int         lvl;
        bit         win;
        bit         over;
        int         speed;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] m_lock;
    int         m_level, m_speed;
    bit         m_win, m_over;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lock = 8'hFF; m_level = 0; m_speed = 200; m_win = 0; m_over = 0;
    endtask

    // Game rules: the new stack is what the block and the old stack share.
    task automatic model_press(input logic [7:0] blk);
        exp_t e;
        e.skip = 0;
        e.prev_lock = m_lock;
        e.prev_level = m_level;
        if (!m_win && !m_over) begin
            if ((blk & m_lock) == 8'h00) m_over = 1;
            else begin
                m_lock = blk & m_lock;
                m_level = m_level + 1;
`ifdef SPEEDUP_EN
                m_speed = (m_speed - 20 > 40) ? m_speed - 20 : 40;
`endif
                if (m_level == 8) m_win = 1;
            end
        end
        e.lock = m_lock; e.lvl = m_level; e.win = m_win; e.over = m_over; e.speed = m_speed;
        sb.push_back(e);
    endtask

    task automatic do_tick();
        repeat (3) @(negedge clk);
        sampleTick = 1'b1;
        @(negedge clk);
        sampleTick = 1'b0;
    endtask

    task automatic press(input logic [7:0] blk, input int hold);
        blockLoc = blk;
        if (hold >= 20) model_press(blk);
        stopBtn = 1'b1;
        repeat (hold) do_tick();
        stopBtn = 1'b0;
        repeat (2) do_tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_lock"}, lockLoc, 8'hFF);
        check({tag, "_level"}, level, 0);
        check({tag, "_speed"}, speedDiv, 200);
        check({tag, "_win"}, gameWin, 0);
        check({tag, "_over"}, gameOver, 0);
        check({tag, "_pulse"}, stopPulse, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstBtn = 1'b1; sampleTick = 1'b0; stopBtn = 1'b0;
        repeat (2) @(negedge clk);
        rstBtn = 1'b0;
        model_reset();
    endtask

    // Monitor: every stopPulse must have been predicted; state is checked one cycle
    // later (still old) and two cycles later (updated).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("win_over_exclusive", int'(gameWin && gameOver), 0);
            if (stopPulse && !rstBtn) begin
                check("pulse_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    @(negedge clk);
                    if (!e.skip) begin
                        check("lock_n1", lockLoc, e.prev_lock);
                        check("level_n1", level, e.prev_level);
                    end
                    @(negedge clk);
                    if (!e.skip) begin
                        check("lock_n2", lockLoc, e.lock);
                        check("level_n2", level, e.lvl);
                        check("win_n2", gameWin, e.win);
                        check("over_n2", gameOver, e.over);
                        check("speed_n2", speedDiv, e.speed);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] blk;
        int         p, w;
        bit         found;
        exp_t       sk;

        model_reset();
        repeat (3) @(negedge clk);
        rstBtn = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        // Bounces shorter than the debounce window must not pulse.
        press(8'h18, 5);
        press(8'h18, 19);
        check("bounce_level", level, 0);
        press(8'h18, 20);
        press(8'h30, 100);
        check("partial_lock", lockLoc, 8'h10);
        press(8'h01, 25);
        press(8'h10, 25);
        press(8'h10, 30);
        check("over_held_lock", lockLoc, 8'h10);
        do_reset();
        check_reset_vals("reset2");

        // Straight run to a win, then a press after the win.
        for (int i = 0; i < 9; i++) press(8'h80, 20 + (i % 3));
        check("win_level", level, 8);
        check("win_flag", gameWin, 1);
        do_reset();

        // Random games, with occasional bounces and zero-width blocks.
        for (int g = 0; g < 6; g++) begin
            for (int k = 0; k < 12; k++) begin
                w = $urandom_range(1, 4);
                p = ((1 << w) - 1) << $urandom_range(0, 7);
                blk = p[7:0];
                if ($urandom_range(0, 1) == 1) blk = blk | (m_lock & (~m_lock + 8'd1));
                if ($urandom_range(0, 15) == 0) blk = 8'h00;
                if ($urandom_range(0, 3) == 0) press(blk, $urandom_range(1, 19));
                press(blk, $urandom_range(20, 40));
            end
            do_reset();
        end

        // Reset landing on the judging cycle wipes the pending update.
        blockLoc = 8'h18;
        sk.skip = 1; sk.prev_lock = 0; sk.prev_level = 0; sk.lock = 0; sk.lvl = 0;
        sk.win = 0; sk.over = 0; sk.speed = 0;
        sb.push_back(sk);
        stopBtn = 1'b1;
        found = 0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            sampleTick = (c % 5 == 4);
            if (stopPulse) found = 1;
        end
        sampleTick = 1'b0;
        check("rst_check_pulse_seen", found, 1);
        if (found) begin
            @(negedge clk);
            rstBtn = 1'b1;
            stopBtn = 1'b0;
            @(negedge clk);
            rstBtn = 1'b0;
            model_reset();
            check_reset_vals("rst_in_check");
        end
        repeat (20) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
